fetch_unit: RTL and testbench

Instruction fetch stage of the processor. Holds the program counter, issues req/ack reads to instruction memory, and presents one fetched instruction per cycle to decode. It consumes the taken-branch command and target from branch resolution and redirects fetch, flushing any wrong-path instruction. A one-entry holding register absorbs a memory response that arrives while decode is stalled.

---
 rtl/processor_pkg.sv | 19 +
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: fetch FSM encoding and default datapath widths.
package processor_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

  // Fetch FSM state encoding (2-bit)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  // Memory request is driven only while a read is being issued or drained
  function automatic logic is_req_state(input logic [1:0] st);
    return (st == ST_REQ) || (st == ST_DISCARD);
  endfunction

endpackage : processor_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack imem reads, one-entry hold buffer,
// branch redirect with flush and wrong-path response discard.
module fetch_unit
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iBranchCmd,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic               iStall,
  output logic               oImemReq,
  output logic [ADDR_W-1:0]  oImemAddr,
  input  logic               iImemAck,
  input  logic [INSTR_W-1:0] iImemData,
  output logic [INSTR_W-1:0] oInstr,
  output logic [ADDR_W-1:0]  oInstrPC,
  output logic               oInstrValid,
  output logic               oFlush
);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
  logic               flush_q, flush_d;
  logic               consume;

  // Next-state and datapath update; branch redirect overrides everything else
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    flush_d      = 1'b0;
    consume      = valid_q && !iStall;

    if (consume) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (iImemAck) begin
          pc_d = pc_q + ADDR_W'(1);
          if (!valid_q || !iStall) begin
            instr_d    = iImemData;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
          end else begin
            hold_instr_d = iImemData;
            hold_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!iStall) begin
          instr_d    = hold_instr_q;
          instr_pc_d = hold_pc_q;
          valid_d    = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_DISCARD: begin
        // Old-address response is dropped; fetch restarts at the redirected PC
        if (iImemAck) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (iBranchCmd) begin
      pc_d         = iBranchTarget;
      valid_d      = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      flush_d      = 1'b1;
      if (is_req_state(state_q) && !iImemAck) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // Address stays on the in-flight request while draining, else follows PC
  always_comb begin
    addr_d = (state_d == ST_DISCARD) ? addr_q : pc_d;
    req_d  = is_req_state(state_d);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      flush_q      <= flush_d;
    end
  end

  assign oImemReq    = req_q;
  assign oImemAddr   = addr_q;
  assign oInstr      = instr_q;
  assign oInstrPC    = instr_pc_q;
  assign oInstrValid = valid_q;
  assign oFlush      = flush_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable instruction memory.
module tb_fetch_unit;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  logic               clk;
  logic               rst_n;
  logic               branch_cmd;
  logic [ADDR_W-1:0]  branch_target;
  logic               stall;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               flush;

  logic mem_en;
  int   mem_lat;
  int   wait_cnt;
  int   n_checks;
  int   n_fail;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (16'h0010)
  ) dut (
    .iClk          (clk),
    .iRst_n        (rst_n),
    .iBranchCmd    (branch_cmd),
    .iBranchTarget (branch_target),
    .iStall        (stall),
    .oImemReq      (imem_req),
    .oImemAddr     (imem_addr),
    .iImemAck      (imem_ack),
    .iImemData     (imem_data),
    .oInstr        (instr),
    .oInstrPC      (instr_pc),
    .oInstrValid   (instr_valid),
    .oFlush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after mem_lat wait cycles, data = addr ^ 0xA5A5
  always_ff @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack  = imem_req && mem_en && (wait_cnt >= mem_lat);
  assign imem_data = imem_addr ^ 16'hA5A5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(imem_req),    32'h0);
    check_eq({tag, "_addr"},  32'(imem_addr),   32'h0010);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'h0);
    check_eq({tag, "_instr"}, 32'(instr),       32'h0);
    check_eq({tag, "_ipc"},   32'(instr_pc),    32'h0);
    check_eq({tag, "_flush"}, 32'(flush),       32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; branch_cmd = 1'b0; branch_target = '0; stall = 1'b0;
    mem_en = 1'b1; mem_lat = 0;

    // Reset
    step(); step(); step();
    check_reset_outputs("rst");

    // Release and zero-wait streaming
    rst_n = 1'b1;
    step();
    check_eq("rel_req",  32'(imem_req),  32'h1);
    check_eq("rel_addr", 32'(imem_addr), 32'h0010);
    check_eq("rel_valid",32'(instr_valid), 32'h0);
    step();
    check_eq("s0_pc",    32'(instr_pc), 32'h0010);
    check_eq("s0_instr", 32'(instr),    32'hA5B5);
    check_eq("s0_valid", 32'(instr_valid), 32'h1);
    step();
    check_eq("s1_pc",    32'(instr_pc), 32'h0011);
    check_eq("s1_instr", 32'(instr),    32'hA5B4);
    step();
    check_eq("s2_pc",    32'(instr_pc), 32'h0012);
    check_eq("s2_instr", 32'(instr),    32'hA5B7);

    // Stall: response for 0x0013 goes to hold, output frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stl_pc",    32'(instr_pc),    32'h0012);
      check_eq("stl_valid", 32'(instr_valid), 32'h1);
      check_eq("stl_req",   32'(imem_req),    32'h0);
    end
    stall = 1'b0;
    step();
    check_eq("rls_pc",    32'(instr_pc),  32'h0013);
    check_eq("rls_instr", 32'(instr),     32'hA5B6);
    check_eq("rls_req",   32'(imem_req),  32'h1);
    check_eq("rls_addr",  32'(imem_addr), 32'h0014);
    step();
    check_eq("rls2_pc",   32'(instr_pc),  32'h0014);

    // Two-cycle memory: one instruction per two cycles, address stable
    mem_lat = 1;
    step();
    check_eq("l2a_valid", 32'(instr_valid), 32'h0);
    check_eq("l2a_addr",  32'(imem_addr),   32'h0015);
    check_eq("l2a_req",   32'(imem_req),    32'h1);
    step();
    check_eq("l2b_pc",    32'(instr_pc),    32'h0015);
    check_eq("l2b_valid", 32'(instr_valid), 32'h1);
    check_eq("l2b_addr",  32'(imem_addr),   32'h0016);
    step();
    check_eq("l2c_valid", 32'(instr_valid), 32'h0);
    check_eq("l2c_addr",  32'(imem_addr),   32'h0016);
    step();
    check_eq("l2d_pc",    32'(instr_pc),    32'h0016);

    // Branch with un-acked request to 0x0017: discard its data
    mem_en = 1'b0;
    branch_cmd = 1'b1; branch_target = 16'h0200;
    step();
    branch_cmd = 1'b0;
    check_eq("bd_flush", 32'(flush),       32'h1);
    check_eq("bd_valid", 32'(instr_valid), 32'h0);
    check_eq("bd_req",   32'(imem_req),    32'h1);
    check_eq("bd_addr",  32'(imem_addr),   32'h0017);
    step();
    check_eq("bd2_flush",32'(flush),       32'h0);
    check_eq("bd2_addr", 32'(imem_addr),   32'h0017);
    mem_en = 1'b1;
    step();
    check_eq("bd3_valid",32'(instr_valid), 32'h0);
    check_eq("bd3_addr", 32'(imem_addr),   32'h0200);
    check_eq("bd3_req",  32'(imem_req),    32'h1);
    step();
    check_eq("bd4_valid",32'(instr_valid), 32'h0);
    step();
    check_eq("bd5_pc",   32'(instr_pc),    32'h0200);
    check_eq("bd5_instr",32'(instr),       32'hA7A5);
    mem_lat = 0;

    // Branch during stall with hold full
    stall = 1'b1;
    step();
    check_eq("bh_req",   32'(imem_req),    32'h0);
    check_eq("bh_pc",    32'(instr_pc),    32'h0200);
    branch_cmd = 1'b1; branch_target = 16'h0300;
    step();
    branch_cmd = 1'b0; stall = 1'b0;
    check_eq("bh2_valid",32'(instr_valid), 32'h0);
    check_eq("bh2_flush",32'(flush),       32'h1);
    check_eq("bh2_req",  32'(imem_req),    32'h1);
    check_eq("bh2_addr", 32'(imem_addr),   32'h0300);
    step();
    check_eq("bh3_pc",   32'(instr_pc),    32'h0300);
    check_eq("bh3_instr",32'(instr),       32'hA6A5);

    // Branch with same-cycle ack to 0xFFFF, then PC wrap
    branch_cmd = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_cmd = 1'b0;
    check_eq("bw_addr",  32'(imem_addr),   32'hFFFF);
    check_eq("bw_valid", 32'(instr_valid), 32'h0);
    check_eq("bw_flush", 32'(flush),       32'h1);
    step();
    check_eq("wr_pc",    32'(instr_pc),    32'hFFFF);
    check_eq("wr_instr", 32'(instr),       32'h5A5A);
    check_eq("wr_addr",  32'(imem_addr),   32'h0000);
    step();
    check_eq("wr2_pc",   32'(instr_pc),    32'h0000);
    check_eq("wr2_instr",32'(instr),       32'hA5A5);

    // Reset asserted while a request is waiting
    mem_en = 1'b0;
    step();
    check_eq("mw_req",   32'(imem_req),    32'h1);
    check_eq("mw_addr",  32'(imem_addr),   32'h0001);
    rst_n = 1'b0;
    step();
    check_reset_outputs("mrst");
    rst_n = 1'b1; mem_en = 1'b1;
    step();
    check_eq("rr_req",   32'(imem_req),    32'h1);
    check_eq("rr_addr",  32'(imem_addr),   32'h0010);
    step();
    check_eq("rr_pc",    32'(instr_pc),    32'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
